// File: rtl/m_phase_strobe_gen_if.sv
// m_phase_strobe_gen_if: request, control and phase-strobe bundle for the phase strobe generator
interface m_phase_strobe_gen_if #(
  parameter int PHASES = 11,
  parameter int DWW    = 4
);
  logic              req;
  logic [DWW-1:0]    dwell;
  logic              hold;
  logic              abort;
  logic [PHASES-1:0] ph;
  logic              busy;
  logic              ack;
  logic [3:0]        phn;
  modport master (output req, dwell, hold, abort, input ph, busy, ack, phn);
  modport slave  (input req, dwell, hold, abort, output ph, busy, ack, phn);
endinterface

// File: rtl/m_phase_strobe_gen.sv
// m_phase_strobe_gen: expands one start request into PHASES one-hot strobes with programmable dwell and REQ/ACK completion
module m_phase_strobe_gen #(
  parameter int PHASES = 11,
  parameter int DWW    = 4
) (
  input  logic              clk,
  input  logic              resetl,
  m_phase_strobe_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [DWW-1:0]    cnt;
  logic [PHASES-1:0] ph;
  logic              busy;
  logic              ack;
  logic [3:0]        phn;
  // sequencer: phase walk, dwell countdown, abort/hold handling and completion handshake
  always_ff @(posedge clk or negedge resetl)
    if (!resetl) begin
      state <= IDLE;
      cnt   <= '0;
      ph    <= '0;
      busy  <= 1'b0;
      ack   <= 1'b0;
      phn   <= '0;
    end else
      case (state)
        IDLE:
          if (bus.req) begin
            state <= RUN;
            ph    <= PHASES'(1);
            phn   <= '0;
            busy  <= 1'b1;
            cnt   <= bus.dwell;
          end
        RUN:
          if (bus.abort) begin
            state <= IDLE;
            ph    <= '0;
            busy  <= 1'b0;
            phn   <= '0;
            cnt   <= '0;
          end else if (!bus.hold) begin
            if (cnt != '0)
              cnt <= cnt - 1'b1;
            else if (phn != 4'(PHASES-1)) begin
              ph  <= ph << 1;
              phn <= phn + 4'd1;
              cnt <= bus.dwell;
            end else begin
              state <= DONE;
              ph    <= '0;
              busy  <= 1'b0;
              ack   <= 1'b1;
              phn   <= '0;
            end
          end
        DONE:
          if (!bus.req) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        default: state <= IDLE;
      endcase
  assign bus.ph   = ph;
  assign bus.busy = busy;
  assign bus.ack  = ack;
  assign bus.phn  = phn;
endmodule

// File: tb/tb_m_phase_strobe_gen.sv
// tb_m_phase_strobe_gen: directed vector table plus hand-written multi-cycle sequences for the phase strobe generator
module tb_m_phase_strobe_gen;
  localparam int PHASES = 11;
  localparam int DWW    = 4;
  logic clk = 1'b0;
  logic resetl = 1'b0;
  int errors = 0;
  int checks = 0;
  m_phase_strobe_gen_if #(.PHASES(PHASES), .DWW(DWW)) bus ();
  m_phase_strobe_gen #(.PHASES(PHASES), .DWW(DWW)) dut (.clk(clk), .resetl(resetl), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic              req;
    logic [DWW-1:0]    dwell;
    logic              hold;
    logic              abort;
    logic [PHASES-1:0] ph;
    logic              busy;
    logic              ack;
    logic [3:0]        phn;
  } vec_t;
  vec_t v [12];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [PHASES-1:0] eph, input logic ebusy, input logic eack, input logic [3:0] ephn);
    checks += 4;
    if (bus.ph !== eph) begin errors++; $display("FAIL %s ph got %h expected %h", nm, bus.ph, eph); end
    if (bus.busy !== ebusy) begin errors++; $display("FAIL %s busy got %b expected %b", nm, bus.busy, ebusy); end
    if (bus.ack !== eack) begin errors++; $display("FAIL %s ack got %b expected %b", nm, bus.ack, eack); end
    if (bus.phn !== ephn) begin errors++; $display("FAIL %s phn got %0d expected %0d", nm, bus.phn, ephn); end
  endtask
  initial begin
    int busy_cnt;
    v[0]  = '{1'b0, 4'd0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0};
    v[1]  = '{1'b1, 4'd0, 1'b0, 1'b0, 11'h001, 1'b1, 1'b0, 4'd0};
    v[2]  = '{1'b1, 4'd1, 1'b0, 1'b0, 11'h002, 1'b1, 1'b0, 4'd1};
    v[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 11'h002, 1'b1, 1'b0, 4'd1};
    v[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 11'h004, 1'b1, 1'b0, 4'd2};
    v[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 11'h004, 1'b1, 1'b0, 4'd2};
    v[6]  = '{1'b0, 4'd0, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0, 4'd0};
    v[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0};
    v[8]  = '{1'b1, 4'd0, 1'b0, 1'b1, 11'h001, 1'b1, 1'b0, 4'd0};
    v[9]  = '{1'b1, 4'd0, 1'b0, 1'b0, 11'h002, 1'b1, 1'b0, 4'd1};
    v[10] = '{1'b1, 4'd0, 1'b0, 1'b1, 11'h000, 1'b0, 1'b0, 4'd0};
    v[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0};
    bus.req = 1'b0; bus.dwell = '0; bus.hold = 1'b0; bus.abort = 1'b0;
    #2;
    chk("reset", 11'h000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    resetl = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      bus.req = v[i].req; bus.dwell = v[i].dwell; bus.hold = v[i].hold; bus.abort = v[i].abort;
      step();
      chk($sformatf("vec%0d", i), v[i].ph, v[i].busy, v[i].ack, v[i].phn);
    end
    bus.hold = 1'b0; bus.abort = 1'b0;
    bus.dwell = 4'd0; bus.req = 1'b1;
    for (int k = 0; k < PHASES; k++) begin
      step();
      chk($sformatf("walk_ph%0d", k), 11'(1 << k), 1'b1, 1'b0, 4'(k));
    end
    step();
    chk("walk_ack", 11'h000, 1'b0, 1'b1, 4'd0);
    step();
    chk("walk_ack_held", 11'h000, 1'b0, 1'b1, 4'd0);
    bus.req = 1'b0;
    step();
    chk("walk_ack_drop", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.dwell = 4'd3; bus.req = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < PHASES; k++)
      for (int j = 0; j < 4; j++) begin
        step();
        if (bus.busy) busy_cnt++;
        chk($sformatf("dw3_ph%0d_c%0d", k, j), 11'(1 << k), 1'b1, 1'b0, 4'(k));
      end
    step();
    chk("dw3_ack", 11'h000, 1'b0, 1'b1, 4'd0);
    checks++;
    if (busy_cnt != 44) begin errors++; $display("FAIL dw3_busy_len got %0d expected 44", busy_cnt); end
    bus.req = 1'b0;
    step();
    chk("dw3_idle", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.req = 1'b1;
    for (int s = 0; s < 8; s++) step();
    step();
    chk("hold_p2_entry", 11'h004, 1'b1, 1'b0, 4'd2);
    step();
    bus.hold = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("hold_%0d", s), 11'h004, 1'b1, 1'b0, 4'd2);
    end
    bus.hold = 1'b0;
    step();
    chk("hold_rel1", 11'h004, 1'b1, 1'b0, 4'd2);
    step();
    chk("hold_rel2", 11'h004, 1'b1, 1'b0, 4'd2);
    step();
    chk("hold_p3", 11'h008, 1'b1, 1'b0, 4'd3);
    for (int s = 0; s < 15; s++) step();
    step();
    chk("abort_p7", 11'h080, 1'b1, 1'b0, 4'd7);
    bus.abort = 1'b1;
    step();
    chk("abort_idle", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.abort = 1'b0;
    step();
    chk("abort_restart", 11'h001, 1'b1, 1'b0, 4'd0);
    for (int s = 0; s < 20; s++) step();
    chk("rst_p5", 11'h020, 1'b1, 1'b0, 4'd5);
    resetl = 1'b0;
    #1;
    chk("rst_async", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.req = 1'b0;
    @(negedge clk);
    resetl = 1'b1;
    step();
    chk("rst_idle1", 11'h000, 1'b0, 1'b0, 4'd0);
    step();
    chk("rst_idle2", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.dwell = 4'd0; bus.req = 1'b1;
    for (int k = 0; k < PHASES; k++) step();
    chk("last_ph", 11'h400, 1'b1, 1'b0, 4'd10);
    bus.abort = 1'b1;
    step();
    chk("abort_last", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.abort = 1'b0; bus.req = 1'b0;
    step();
    chk("abort_last_after", 11'h000, 1'b0, 1'b0, 4'd0);
    bus.dwell = 4'd3; bus.req = 1'b1;
    step();
    chk("dchg_entry", 11'h001, 1'b1, 1'b0, 4'd0);
    bus.dwell = 4'd0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("dchg_p0_%0d", s), 11'h001, 1'b1, 1'b0, 4'd0);
    end
    step();
    chk("dchg_p1", 11'h002, 1'b1, 1'b0, 4'd1);
    step();
    chk("dchg_p2", 11'h004, 1'b1, 1'b0, 4'd2);
    bus.req = 1'b0;
    for (int s = 0; s < 8; s++) step();
    chk("reqlow_p10", 11'h400, 1'b1, 1'b0, 4'd10);
    step();
    chk("reqlow_done", 11'h000, 1'b0, 1'b1, 4'd0);
    step();
    chk("reqlow_idle", 11'h000, 1'b0, 1'b0, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
